// File: rtl/core_pkg.sv
// Shared core definitions: widths, reset PC, NOP encoding and the fetch
// queue entry layout.
package core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] word;
    logic [XLEN-1:0] pc;
  } inst_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised in-order FIFO with push/pop/flush and an occupancy count.
// Storage resets to zero so the head reads 0 while the unit is in reset.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

  // Pointer, count and storage update; flush discards every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
      end
      if (pop) r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  fetch_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !flush),
    .pop   (pop && !flush),
    .count (r_count)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Occupancy checks for fetch_fifo: the producers' credit scheme must
// never overflow it, and the consumer must never pop it empty.
module fetch_fifo_chk #(
  parameter int DEPTH = 2
) (
  input logic                       clk,
  input logic                       rst,
  input logic                       push,
  input logic                       pop,
  input logic [$clog2(DEPTH):0]     count
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Occupancy invariants sampled on every active edge outside reset
  always @(posedge clk) begin
    if (!rst) begin
      a_no_overflow:  assert (!(push && (count == CW'(DEPTH))));
      a_no_underflow: assert (!(pop && (count == {CW{1'b0}})));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, in-order
// instruction queue toward decode, and redirect with stale-response drop.
module fetch_unit import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_outstanding;
  logic [CW-1:0]   w_resp_ext;
  logic [CW:0]     w_inflight;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_resp_pc;
  inst_entry_t     w_push_entry;
  inst_entry_t     w_head_entry;

  // Credit uses registered occupancies only; dropped responses still hold credit
  assign w_inflight = {1'b0, w_count} + {1'b0, w_outstanding};
  assign imem_req   = !rst && !redirect && (w_inflight < (CW+1)'(DEPTH));
  assign imem_addr  = r_pc;
  assign w_issue    = imem_req && imem_gnt;
  assign w_resp_ext = {{(CW-1){1'b0}}, imem_rvalid};

  assign w_push = imem_rvalid && (r_drop == {CW{1'b0}}) && !redirect;
  assign w_pop  = inst_valid && inst_ready;

  assign w_push_entry.word = imem_rdata;
  assign w_push_entry.pc   = w_resp_pc;

  assign inst_valid = (w_count != {CW{1'b0}});
  assign inst       = w_head_entry.word;
  assign inst_pc    = w_head_entry.pc;

  // PC advance/redirect and count of responses still to be discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_drop <= {CW{1'b0}};
    end else if (redirect) begin
      r_pc   <= align_pc(redirect_pc);
      r_drop <= w_outstanding - w_resp_ext;
    end else begin
      if (w_issue) r_pc <= r_pc + 32'd4;
      if (imem_rvalid && (r_drop != {CW{1'b0}})) r_drop <= r_drop - CW'(1'b1);
    end
  end

  // In-flight address FIFO: its occupancy is the outstanding-request count
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_issue),
    .wdata (r_pc),
    .pop   (imem_rvalid),
    .flush (1'b0),
    .rdata (w_resp_pc),
    .count (w_outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ILEN + XLEN)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_push_entry),
    .pop   (w_pop),
    .flush (redirect),
    .rdata (w_head_entry),
    .count (w_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based imem model returns ~addr as
// the instruction word; expected values are worked out cycle by cycle.
module tb_fetch_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mq[$];
  bit          rv_en;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic upd_mem();
    imem_rvalid = rv_en && (mq.size() != 0);
    imem_rdata  = imem_rvalid ? ~mq[0] : NOP;
  endtask

  // One clock: record issue/response at the edge, then present next response
  task automatic tick();
    bit          iss;
    bit          rsp;
    logic [31:0] a;
    #1;
    iss = imem_req && imem_gnt;
    rsp = imem_rvalid;
    a   = imem_addr;
    @(posedge clk);
    if (rsp) void'(mq.pop_front());
    if (iss) mq.push_back(a);
    @(negedge clk);
    upd_mem();
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    mq.delete();
    upd_mem();
    @(negedge clk);
    #1;
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  inst,                32'd0);
    chk("rst_pc",    inst_pc,             32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1; rv_en = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0000_0000;
    imem_rvalid = 1'b0; imem_rdata = NOP;

    // Streaming from reset with ready held high
    do_reset();
    chk("t1_c0_req",   {31'd0, imem_req},   32'd1);
    chk("t1_c0_addr",  imem_addr,           32'h0000_0000);
    chk("t1_c0_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t1_c1_req",   {31'd0, imem_req},   32'd1);
    chk("t1_c1_addr",  imem_addr,           32'h0000_0004);
    chk("t1_c1_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t1_c2_req",   {31'd0, imem_req},   32'd0);
    chk("t1_c2_valid", {31'd0, inst_valid}, 32'd1);
    chk("t1_c2_pc",    inst_pc,             32'h0000_0000);
    chk("t1_c2_inst",  inst,                32'hFFFF_FFFF);
    tick();
    chk("t1_c3_req",   {31'd0, imem_req},   32'd1);
    chk("t1_c3_addr",  imem_addr,           32'h0000_0008);
    chk("t1_c3_pc",    inst_pc,             32'h0000_0004);
    chk("t1_c3_inst",  inst,                32'hFFFF_FFFB);
    tick();
    chk("t1_c4_valid", {31'd0, inst_valid}, 32'd0);
    chk("t1_c4_addr",  imem_addr,           32'h0000_000C);
    tick();
    chk("t1_c5_valid", {31'd0, inst_valid}, 32'd1);
    chk("t1_c5_pc",    inst_pc,             32'h0000_0008);
    chk("t1_c5_req",   {31'd0, imem_req},   32'd0);

    // Backpressure: queue fills, requests stop, head frozen, then drains
    inst_ready = 1'b0;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("t2_hold_pc",    inst_pc,             32'h0000_0000);
      chk("t2_hold_inst",  inst,                32'hFFFF_FFFF);
      chk("t2_hold_req",   {31'd0, imem_req},   32'd0);
      if (i < 4) tick();
    end
    inst_ready = 1'b1;
    tick();
    chk("t2_d1_pc",    inst_pc,             32'h0000_0004);
    chk("t2_d1_inst",  inst,                32'hFFFF_FFFB);
    chk("t2_d1_req",   {31'd0, imem_req},   32'd1);
    chk("t2_d1_addr",  imem_addr,           32'h0000_0008);
    tick();
    chk("t2_d2_valid", {31'd0, inst_valid}, 32'd0);
    chk("t2_d2_addr",  imem_addr,           32'h0000_000C);

    // Redirect with two responses still outstanding
    rv_en = 1'b0;
    do_reset();
    tick();
    chk("t3_c1_addr", imem_addr,          32'h0000_0004);
    tick();
    chk("t3_c2_req",  {31'd0, imem_req},  32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0; rv_en = 1'b1; upd_mem();
    #1;
    chk("t3_c3_req",   {31'd0, imem_req},   32'd0);
    chk("t3_c3_valid", {31'd0, inst_valid}, 32'd0);
    chk("t3_c3_addr",  imem_addr,           32'h0000_0100);
    tick();
    chk("t3_c4_req",   {31'd0, imem_req},   32'd1);
    chk("t3_c4_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t3_c5_valid", {31'd0, inst_valid}, 32'd0);
    chk("t3_c5_addr",  imem_addr,           32'h0000_0104);
    tick();
    chk("t3_c6_valid", {31'd0, inst_valid}, 32'd1);
    chk("t3_c6_pc",    inst_pc,             32'h0000_0100);
    chk("t3_c6_inst",  inst,                32'hFFFF_FEFF);

    // Grant withheld: request and address held until accepted
    imem_gnt = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_req",  {31'd0, imem_req}, 32'd1);
      chk("t4_stall_addr", imem_addr,         32'h0000_0000);
      if (i < 2) tick();
    end
    imem_gnt = 1'b1;
    tick();
    chk("t4_gnt_addr", imem_addr,         32'h0000_0004);
    chk("t4_gnt_req",  {31'd0, imem_req}, 32'd1);

    // Redirect coinciding with a response and a pop
    do_reset();
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    chk("t5_rd_req",   {31'd0, imem_req},   32'd0);
    chk("t5_rd_valid", {31'd0, inst_valid}, 32'd1);
    chk("t5_rd_pc",    inst_pc,             32'h0000_0000);
    tick();
    redirect = 1'b0;
    #1;
    chk("t5_c3_valid", {31'd0, inst_valid}, 32'd0);
    chk("t5_c3_addr",  imem_addr,           32'h0000_0200);
    chk("t5_c3_req",   {31'd0, imem_req},   32'd1);
    tick();
    chk("t5_c4_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t5_c5_pc",    inst_pc,             32'h0000_0200);
    chk("t5_c5_inst",  inst,                32'hFFFF_FDFF);

    // Back-to-back redirects, low bits ignored, then PC wrap
    rv_en = 1'b0;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    #1;
    chk("t6_rd0_req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect_pc = 32'hFFFF_FFFF;
    #1;
    chk("t6_rd1_req",  {31'd0, imem_req}, 32'd0);
    chk("t6_rd1_addr", imem_addr,         32'h0000_0040);
    tick();
    redirect = 1'b0;
    #1;
    chk("t6_top_addr", imem_addr,         32'hFFFF_FFFC);
    chk("t6_top_req",  {31'd0, imem_req}, 32'd1);
    tick();
    chk("t6_wrap_addr", imem_addr,         32'h0000_0000);
    chk("t6_wrap_req",  {31'd0, imem_req}, 32'd1);
    rv_en = 1'b1; upd_mem();
    tick();
    chk("t6_out_pc",   inst_pc, 32'hFFFF_FFFC);
    chk("t6_out_inst", inst,    32'h0000_0003);

    // Reset while the queue holds an entry
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
